// File: rtl/if_fetch_pipe_pkg.sv
// Shared definitions for the fetch pipeline: FSM state encoding and default
// reset PC / bubble instruction values.
package if_fetch_pipe_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PIPE_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PIPE_NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_pipe_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones, cleared by rst.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_pipe.sv
// Fetch stage: PC register, 1-cycle synchronous imem interface, one-entry skid
// for the in-flight word, and the IF/ID register, driven by hazard stall/redirect.
module if_fetch_pipe
    import if_fetch_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PIPE_RESET_PC,
    parameter logic [31:0] NOP_INST = PIPE_NOP_INST,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pcw_ctrl,
    input  logic             if_id_reg_ctrl,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      if_id_inst,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  rsp_pc_q;
    logic         rsp_vld_q;
    logic [31:0]  skid_q;
    logic         advance;

    // A split request from the hazard unit must hold both PC and IF/ID.
    assign advance   = pcw_ctrl & if_id_reg_ctrl;
    assign imem_addr = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            pc_q        <= RESET_PC;
            rsp_pc_q    <= '0;
            rsp_vld_q   <= 1'b0;
            skid_q      <= '0;
            if_id_inst  <= NOP_INST;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end else if (br_taken) begin
            state_q     <= FILL;
            pc_q        <= {br_target[31:2], 2'b00};
            rsp_vld_q   <= 1'b0;
            skid_q      <= '0;
            if_id_inst  <= NOP_INST;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (advance) begin
                        rsp_pc_q    <= pc_q;
                        pc_q        <= pc_q + 32'd4;
                        rsp_vld_q   <= 1'b1;
                        if_id_inst  <= NOP_INST;
                        if_id_pc4   <= '0;
                        if_id_valid <= 1'b0;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    if (advance) begin
                        if_id_inst  <= imem_rdata;
                        if_id_pc4   <= rsp_pc_q + 32'd4;
                        if_id_valid <= 1'b1;
                        rsp_pc_q    <= pc_q;
                        pc_q        <= pc_q + 32'd4;
                    end else begin
                        skid_q  <= imem_rdata;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    // imem keeps seeing pc_q while held, so its next word matches the new rsp_pc_q.
                    if (advance) begin
                        if_id_inst  <= skid_q;
                        if_id_pc4   <= rsp_pc_q + 32'd4;
                        if_id_valid <= 1'b1;
                        rsp_pc_q    <= pc_q;
                        pc_q        <= pc_q + 32'd4;
                        state_q     <= RUN;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~advance & ~br_taken),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (br_taken),
        .count (flush_cnt)
    );

endmodule
